// File: rtl/prog_loader.sv
// Boot loader: assembles a length-prefixed byte stream into 32-bit words, writes them from
// address 0 while holding the CPU, then pulses cpu_start. Optional checksum: PROG_LOADER_CSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              load,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
`ifdef PROG_LOADER_CSUM_EN
    StCsum,
`endif
    StStart,
    StDone,
    StErr
  } state_e;

  localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

  state_e      state_q;
  logic [15:0] n_q;
  logic [15:0] wcnt_q;
  logic [1:0]  bidx_q;
  logic [23:0] wbuf_q;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic        too_big;
  logic        last_word;
  logic [31:0] word_full;
  logic        addr_max;

  always_comb begin
    accept    = in_valid & in_ready;
    len_full  = {n_q[15:8], in_data};
    too_big   = {1'b0, len_full} > MaxWords;
    last_word = (wcnt_q == (n_q - 16'd1));
    word_full = {wbuf_q, in_data};
    addr_max  = &mem_addr;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      n_q       <= '0;
      wcnt_q    <= '0;
      bidx_q    <= '0;
      wbuf_q    <= '0;
`ifdef PROG_LOADER_CSUM_EN
      csum_q    <= '0;
`endif
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      cpu_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      // Address advances once the write cycle has presented it; saturate instead of wrapping.
      if (mem_we && !addr_max) mem_addr <= mem_addr + ADDR_W'(1);

`ifdef PROG_LOADER_CSUM_EN
      if (accept) csum_q <= csum_q ^ in_data;
`endif

      case (state_q)
        StIdle, StDone, StErr: begin
          if (load) begin
            state_q  <= StLenHi;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_addr <= '0;
            wcnt_q   <= '0;
            bidx_q   <= '0;
            n_q      <= '0;
`ifdef PROG_LOADER_CSUM_EN
            csum_q   <= '0;
`endif
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end

        StLenHi: begin
          if (accept) begin
            n_q[15:8] <= in_data;
            state_q   <= StLenLo;
          end
        end

        StLenLo: begin
          if (accept) begin
            n_q <= len_full;
            if (too_big) begin
              state_q  <= StErr;
              err      <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else if (len_full == 16'd0) begin
`ifdef PROG_LOADER_CSUM_EN
              state_q  <= StCsum;
`else
              state_q  <= StStart;
              in_ready <= 1'b0;
`endif
            end else begin
              state_q <= StData;
            end
          end
        end

        StData: begin
          if (accept) begin
            wbuf_q <= word_full[23:0];
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              mem_wdata <= word_full;
              mem_we    <= 1'b1;
              wcnt_q    <= wcnt_q + 16'd1;
              if (last_word) begin
`ifdef PROG_LOADER_CSUM_EN
                state_q  <= StCsum;
`else
                state_q  <= StStart;
                in_ready <= 1'b0;
`endif
              end
            end
          end
        end

`ifdef PROG_LOADER_CSUM_EN
        StCsum: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum_q) begin
              state_q <= StStart;
            end else begin
              state_q <= StErr;
              err     <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
`endif

        // One idle cycle here keeps cpu_start strictly after the final mem_we.
        StStart: begin
          cpu_start <= 1'b1;
          cpu_hold  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state_q   <= StDone;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
